fp_inv_share_arb: RTL
=====================

Name: fp_inv_share_arb

Overview:
- Shares one `fp_inverter` reciprocal datapath (single-precision, WIDTH bits) among NUM_REQ requesters in the LCMV weight-computation path.
- Arbitrates round-robin, issues at most one operand per cycle and retimes the combinational inverter through LAT register stages.
- Returns each result on a shared bus, tagged by requester.
- Sits between the covariance-inverse/normalisation engines and the `fp_inverter` instance it owns.

Parameters:
- WIDTH, 32, float word width passed to the `fp_inverter` instance
- NUM_REQ, 4, number of requesters (2..16)
- LAT, 2, result register stages after the inverter (1..8)
- TAG_W, $clog2(NUM_REQ), width of the result tag (derived, not overridable)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  NUM_REQ*WIDTH  operands; requester i at bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; operand accepted when req_valid[i] && req_ready[i]
- hold  in  1  when high, no new grants; in-flight ops still complete
- res_valid  out  1  result valid pulse
- res_tag  out  TAG_W  requester index of the result
- res_data  out  WIDTH  reciprocal result
- busy  out  1  high while any op is in flight

Behaviour:
- **Arbitration**
  - req_ready is combinational from req_valid, hold and the registered priority pointer ptr.
  - req_ready = 0 when hold = 1 or rst = 1.
  - Otherwise req_ready is one-hot on the first i with req_valid[i], searching from ptr upward and wrapping NUM_REQ-1 -> 0.
  - req_ready is all-zero if no req_valid is set.
  - On a grant to g: ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
  - Requesters must hold req_data stable while req_valid is high and not granted.
  - Dropping req_valid without a grant is permitted.
- **Datapath**
  - The granted operand muxes into the `fp_inverter` in the grant cycle.
  - The output enters a LAT-deep pipeline of {valid, tag, data}. No backpressure; the pipeline always advances.
- **Latency and throughput**
  - Grant at rising edge t -> res_valid = 1 for exactly one cycle at edge t+LAT, with res_tag = g and res_data = inverter(operand).
  - Throughput is one op per cycle. Back-to-back grants yield back-to-back results in grant order.
- **Result bus hygiene**: res_tag and res_data hold their last values when res_valid = 0. Consumers must qualify with res_valid.
- **busy**: registered; 1 iff any pipeline stage valid is set or a grant occurred this cycle.
- **Fairness**: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... Maximum wait is NUM_REQ-1 cycles plus hold time.
- **Reset**
  - ptr = 0; all pipeline valids = 0; res_valid = 0; res_tag = 0; res_data = 0; busy = 0.
  - Reset mid-operation discards in-flight ops; no res_valid is emitted for them.
  - No grant in any cycle where rst = 1.
- **hold**
  - Asserting hold in the cycle a requester would be granted suppresses the grant. ptr is unchanged.
  - Deasserting hold resumes from the same ptr.
- **Arithmetic**: none beyond the inverter; specials (0, inf, NaN) pass through with `fp_inverter` semantics unchanged.

Optional Feature:
- Macro: FP_INV_ARB_STATS_EN.
- When defined, adds output `grant_cnt` (NUM_REQ*16 bits, slice i for requester i).
  - Each slice is a per-requester grant counter incremented on each grant.
  - Saturates at 16'hFFFF; cleared by rst.
- When undefined, the port and the counters are absent; all other behaviour is identical.

Test Plan:
- Single op, LAT=2: reset, then req_valid[1] = 1 with operand 0x40000000 (2.0).
  - Required: req_ready = 4'b0010 in the same cycle.
  - Required: 2 cycles later, res_valid = 1, res_tag = 1, res_data = 0x3F000000 (0.5); busy low the following cycle.
- Round-robin: all 4 requesters held valid for 8 cycles, operands 0xC0800000 (-4.0) on each.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Required: 8 consecutive res_valid pulses, tags in the same order, each res_data = 0xBE800000 (-0.25).
- Wrap and skip: ptr = 3 after a grant to requester 2; then only req_valid[0] and req_valid[2] are set.
  - Required: requester 0 granted first, then 2; ptr ends at 3.
- Hold: all valid, hold = 1 for 3 cycles, then 0.
  - Required: req_ready = 0 and no res_valid attributable to that window.
  - Required: after release, grants resume from the pre-hold ptr.
- Reset mid-flight: grant op at t, assert rst at t+1 for 1 cycle.
  - Required: no res_valid at t+2 or t+3; ptr = 0; busy = 0; the next request to 3 is granted at first post-reset cycle.
- With FP_INV_ARB_STATS_EN:
  - 5 grants to requester 2 -> grant_cnt slice 2 = 5, other slices 0.
  - Force 70000 grants -> slice saturates at 0xFFFF.

Source files
------------

// File: rtl/fp_inv_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : fp_inv_share_arb (+ fp_inverter)
//  Purpose  : Round-robin arbiter sharing one combinational single-precision
//             reciprocal among NUM_REQ requesters, retimed through LAT stages.
//             Optional per-requester grant counters: FP_INV_ARB_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================

module fp_inverter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    localparam int EW = 8;
    localparam int MW = WIDTH - 1 - EW;

    logic              w_sgn;
    logic [EW-1:0]     w_exp;
    logic [MW-1:0]     w_man;
    logic [MW+1:0]     w_rem;
    logic [MW-1:0]     w_q;
    logic signed [9:0] w_re;

    always_comb begin
        w_sgn = a[WIDTH-1];
        w_exp = a[WIDTH-2:MW];
        w_man = a[MW-1:0];
        // Long division of 2.0 by the significand; the leading quotient bit is always 1.
        w_rem = {1'b1, {(MW+1){1'b0}}} - {2'b01, w_man};
        w_rem = w_rem << 1;
        w_q   = '0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (w_rem >= {2'b01, w_man}) begin
                w_rem  = w_rem - {2'b01, w_man};
                w_q[i] = 1'b1;
            end
            w_rem = w_rem << 1;
        end
        w_re = $signed({2'b00, w_exp});
        w_re = ((w_man == '0) ? 10'sd254 : 10'sd253) - w_re;

        y = '0;
        if (w_exp == '1) begin
            y = (w_man != '0) ? {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}}
                              : {w_sgn, {(WIDTH-1){1'b0}}};
        end else if (w_exp == '0) begin
            y = {w_sgn, {EW{1'b1}}, {MW{1'b0}}};
        end else if (w_re > 10'sd0) begin
            y = {w_sgn, w_re[EW-1:0], (w_man == '0) ? {MW{1'b0}} : w_q};
        end else begin
            y = {w_sgn, {(WIDTH-1){1'b0}}};
        end
    end
endmodule

module fp_inv_share_arb #(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    parameter  int LAT     = 2,
    localparam int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     hold,
    output logic                     res_valid,
    output logic [TAG_W-1:0]         res_tag,
    output logic [WIDTH-1:0]         res_data,
`ifdef FP_INV_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]    grant_cnt,
`endif
    output logic                     busy
);
    logic [TAG_W-1:0] r_ptr;
    logic [TAG_W-1:0] w_gnt_idx;
    logic             w_grant;
    logic [WIDTH-1:0] w_operand;
    logic [WIDTH-1:0] w_inv;
    logic             w_inflight;
    logic             r_busy;
    logic             r_v    [LAT];
    logic [TAG_W-1:0] r_tag  [LAT];
    logic [WIDTH-1:0] r_data [LAT];
    int               w_idx;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        w_grant   = 1'b0;
        w_gnt_idx = '0;
        req_ready = '0;
        w_idx     = 0;
        if (!rst && !hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
                if (!w_grant && req_valid[w_idx[TAG_W-1:0]]) begin
                    w_grant   = 1'b1;
                    w_gnt_idx = w_idx[TAG_W-1:0];
                end
            end
        end
        req_ready[w_gnt_idx] = w_grant;
    end

    assign w_operand = req_data[w_gnt_idx*WIDTH +: WIDTH];

    fp_inverter #(.WIDTH(WIDTH)) u_inv (
        .a (w_operand),
        .y (w_inv)
    );

    // Ops that will still be in flight after this edge, excluding the output stage.
    always_comb begin
        w_inflight = 1'b0;
        for (int i = 0; i < LAT - 1; i++) w_inflight = w_inflight | r_v[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_busy <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                r_v[i]    <= 1'b0;
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_grant)
                r_ptr <= (w_gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_busy <= w_grant | w_inflight;
            r_v[0] <= w_grant;
            if (w_grant) begin
                r_tag[0]  <= w_gnt_idx;
                r_data[0] <= w_inv;
            end
            // Payload only moves with a valid so the bus holds its last result.
            for (int i = 1; i < LAT; i++) begin
                r_v[i] <= r_v[i-1];
                if (r_v[i-1]) begin
                    r_tag[i]  <= r_tag[i-1];
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign res_valid = r_v[LAT-1];
    assign res_tag   = r_tag[LAT-1];
    assign res_data  = r_data[LAT-1];
    assign busy      = r_busy;

`ifdef FP_INV_ARB_STATS_EN
    logic [15:0] r_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
        end else if (w_grant && (r_cnt[w_gnt_idx] != 16'hFFFF)) begin
            r_cnt[w_gnt_idx] <= r_cnt[w_gnt_idx] + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        assign grant_cnt[gi*16 +: 16] = r_cnt[gi];
    end
`endif
endmodule
`default_nettype wire
